// File: rtl/dpll_pkg.sv
// Shared definitions for the DPLL search sequencer.
//   MAX_VARS      : maximum variable count and decision depth (trail stack depth)
//   MAX_VARS_BITS : index width; 2**MAX_VARS_BITS > MAX_VARS so an index can equal num_vars
//   ctrl_state_t  : sequencer state encoding
//   trail_entry_t : one decision on the trail {dec_idx, var_idx, val, flipped}
package dpll_pkg;

  localparam int unsigned MAX_VARS      = 16;
  localparam int unsigned MAX_VARS_BITS = 5;

  typedef logic [MAX_VARS_BITS-1:0] idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StDecide,
    StProp,
    StBacktrack,
    StSat,
    StUnsat
  } ctrl_state_t;

  typedef struct packed {
    idx_t dec_idx;  // decider position the decision was taken at
    idx_t var_idx;  // decided variable
    logic val;      // currently assigned value
    logic flipped;  // both polarities have now been tried
  } trail_entry_t;

endpackage

// File: rtl/dpll_control_dec_trail_stack.sv
// Decision trail stack.
//   clk_i, rst_ni  : clock, asynchronous active-low clear of the stack pointer
//   clear_i        : synchronous empty
//   push_i         : push push_entry_i (ignored when full)
//   pop_i          : discard the top entry (ignored when empty)
//   flip_i         : mark the top entry flipped and invert its value (ignored when empty)
//   top_o          : current top entry ('0 when empty)
//   sp_o           : number of entries held (0..MAX_VARS)
//   empty_o/full_o : occupancy flags
// Operation priority: clear, push, pop, flip.
module dec_trail_stack
  import dpll_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flip_i,
  input  trail_entry_t push_entry_i,
  output trail_entry_t top_o,
  output idx_t         sp_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned AddrW = $clog2(MAX_VARS);

  trail_entry_t mem_q [MAX_VARS];
  idx_t         sp_q, sp_d;
  logic [AddrW-1:0] top_addr;
  logic [AddrW-1:0] wr_addr;
  trail_entry_t flipped_entry;

  assign empty_o  = (sp_q == '0);
  assign full_o   = (sp_q == MAX_VARS_BITS'(MAX_VARS));
  assign top_addr = AddrW'(sp_q - 1'b1);
  assign wr_addr  = AddrW'(sp_q);
  assign top_o    = empty_o ? '0 : mem_q[top_addr];
  assign sp_o     = sp_q;

  always_comb begin
    flipped_entry         = mem_q[top_addr];
    flipped_entry.flipped = 1'b1;
    flipped_entry.val     = ~mem_q[top_addr].val;
  end

  always_comb begin
    sp_d = sp_q;
    if (clear_i) begin
      sp_d = '0;
    end else if (push_i && !full_o) begin
      sp_d = sp_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage needs no reset: entries above sp are never observed.
  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      if (push_i && !full_o) begin
        mem_q[wr_addr] <= push_entry_i;
      end else if (!pop_i && flip_i && !empty_o) begin
        mem_q[top_addr] <= flipped_entry;
      end
    end
  end

endmodule

// File: rtl/dpll_control.sv
// DPLL search sequencer. Walks the decider through its variable list, issues each
// decision to the BCP engine, keeps a trail of decisions and on a conflict backtracks
// chronologically by flipping the most recent unflipped decision.
//   clock, reset        : system clock, asynchronous active-low reset
//   start, num_vars     : begin a solve of num_vars variables (only when not busy)
//   dec_*               : decider control (advance / reposition) and its current position
//   bcp_*               : assignment request to BCP and its done/conflict response
//   bt_valid, bt_level  : undo every assignment at level >= bt_level
//   busy, sat, unsat    : solve status
// All control and data outputs are registered, so a pulse decided in a state is seen
// by the decider and BCP during the following cycle.
module dpll_control
  import dpll_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [MAX_VARS_BITS-1:0] num_vars,
  output logic                     dec_en,
  output logic                     dec_rw,
  output logic [MAX_VARS_BITS-1:0] back_dec_idx,
  input  logic [MAX_VARS_BITS-1:0] dec_idx_in,
  input  logic [MAX_VARS_BITS-1:0] var_idx_in,
  input  logic                     val_in,
  output logic                     bcp_req,
  output logic [MAX_VARS_BITS-1:0] bcp_var,
  output logic                     bcp_val,
  output logic [MAX_VARS_BITS-1:0] bcp_level,
  input  logic                     bcp_done,
  input  logic                     bcp_conflict,
  output logic                     bt_valid,
  output logic [MAX_VARS_BITS-1:0] bt_level,
  output logic                     busy,
  output logic                     sat,
  output logic                     unsat
);

  ctrl_state_t state_q, state_d;
  idx_t        num_vars_q, num_vars_d;

  logic dec_en_q, dec_en_d;
  logic dec_rw_q, dec_rw_d;
  idx_t back_dec_idx_q, back_dec_idx_d;
  logic bcp_req_q, bcp_req_d;
  idx_t bcp_var_q, bcp_var_d;
  logic bcp_val_q, bcp_val_d;
  idx_t bcp_level_q, bcp_level_d;
  logic bt_valid_q, bt_valid_d;
  idx_t bt_level_q, bt_level_d;

  logic         stk_clear, stk_push, stk_pop, stk_flip;
  trail_entry_t stk_push_entry, stk_top;
  idx_t         stk_sp;
  logic         stk_empty, stk_full;

  logic idle_like;
  logic all_decided;

  assign idle_like   = (state_q == StIdle) || (state_q == StSat) || (state_q == StUnsat);
  assign all_decided = (dec_idx_in == num_vars_q);

  dec_trail_stack u_trail (
    .clk_i        (clock),
    .rst_ni       (reset),
    .clear_i      (stk_clear),
    .push_i       (stk_push),
    .pop_i        (stk_pop),
    .flip_i       (stk_flip),
    .push_entry_i (stk_push_entry),
    .top_o        (stk_top),
    .sp_o         (stk_sp),
    .empty_o      (stk_empty),
    .full_o       (stk_full)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      num_vars_q <= '0;
    end else begin
      state_q    <= state_d;
      num_vars_q <= num_vars_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    num_vars_d = num_vars_q;
    case (state_q)
      StIdle, StSat, StUnsat: begin
        if (start) begin
          state_d    = StInit;
          num_vars_d = num_vars;
        end
      end
      StInit:   state_d = StDecide;
      StDecide: state_d = all_decided ? StSat : StProp;
      StProp: begin
        if (bcp_done) begin
          state_d = bcp_conflict ? StBacktrack : StDecide;
        end
      end
      StBacktrack: begin
        if (stk_empty) begin
          state_d = StUnsat;
        end else if (!stk_top.flipped) begin
          state_d = StProp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and trail-control logic; data outputs hold their last issued value.
  always_comb begin
    dec_en_d       = 1'b0;
    dec_rw_d       = dec_rw_q;
    back_dec_idx_d = back_dec_idx_q;
    bcp_req_d      = 1'b0;
    bcp_var_d      = bcp_var_q;
    bcp_val_d      = bcp_val_q;
    bcp_level_d    = bcp_level_q;
    bt_valid_d     = 1'b0;
    bt_level_d     = bt_level_q;
    stk_clear      = 1'b0;
    stk_push       = 1'b0;
    stk_pop        = 1'b0;
    stk_flip       = 1'b0;
    stk_push_entry = '{dec_idx: dec_idx_in, var_idx: var_idx_in, val: val_in, flipped: 1'b0};
    case (state_q)
      StIdle, StSat, StUnsat: begin
        if (start) begin
          stk_clear      = 1'b1;
          dec_en_d       = 1'b1;
          dec_rw_d       = 1'b1;
          back_dec_idx_d = '0;
        end
      end
      StDecide: begin
        if (!all_decided) begin
          stk_push    = ~stk_full;
          bcp_req_d   = 1'b1;
          bcp_var_d   = var_idx_in;
          bcp_val_d   = val_in;
          bcp_level_d = stk_sp + 1'b1;
          dec_en_d    = 1'b1;
          dec_rw_d    = 1'b0;
        end
      end
      StBacktrack: begin
        if (!stk_empty) begin
          bt_valid_d = 1'b1;
          bt_level_d = stk_sp;
          if (stk_top.flipped) begin
            stk_pop = 1'b1;
          end else begin
            // Try the other polarity and restart the decider just past this variable.
            stk_flip       = 1'b1;
            bcp_req_d      = 1'b1;
            bcp_var_d      = stk_top.var_idx;
            bcp_val_d      = ~stk_top.val;
            bcp_level_d    = stk_sp;
            dec_en_d       = 1'b1;
            dec_rw_d       = 1'b1;
            back_dec_idx_d = stk_top.dec_idx + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dec_en_q       <= 1'b0;
      dec_rw_q       <= 1'b0;
      back_dec_idx_q <= '0;
      bcp_req_q      <= 1'b0;
      bcp_var_q      <= '0;
      bcp_val_q      <= 1'b0;
      bcp_level_q    <= '0;
      bt_valid_q     <= 1'b0;
      bt_level_q     <= '0;
    end else begin
      dec_en_q       <= dec_en_d;
      dec_rw_q       <= dec_rw_d;
      back_dec_idx_q <= back_dec_idx_d;
      bcp_req_q      <= bcp_req_d;
      bcp_var_q      <= bcp_var_d;
      bcp_val_q      <= bcp_val_d;
      bcp_level_q    <= bcp_level_d;
      bt_valid_q     <= bt_valid_d;
      bt_level_q     <= bt_level_d;
    end
  end

  assign dec_en       = dec_en_q;
  assign dec_rw       = dec_rw_q;
  assign back_dec_idx = back_dec_idx_q;
  assign bcp_req      = bcp_req_q;
  assign bcp_var      = bcp_var_q;
  assign bcp_val      = bcp_val_q;
  assign bcp_level    = bcp_level_q;
  assign bt_valid     = bt_valid_q;
  assign bt_level     = bt_level_q;
  assign busy         = !idle_like;
  assign sat          = (state_q == StSat);
  assign unsat        = (state_q == StUnsat);

endmodule

// File: tb/tb_dpll_control.sv
// Bench for dpll_control: a decider model and a scripted/random BCP responder drive the
// DUT; a trail-based DPLL reference model predicts every request, backtrack and verdict.
module tb_dpll_control;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] num_vars = '0;
  logic       dec_en, dec_rw;
  logic [4:0] back_dec_idx;
  logic [4:0] dec_idx_in, var_idx_in;
  logic       val_in;
  logic       bcp_req;
  logic [4:0] bcp_var;
  logic       bcp_val;
  logic [4:0] bcp_level;
  logic       bcp_done = 1'b0;
  logic       bcp_conflict = 1'b0;
  logic       bt_valid;
  logic [4:0] bt_level;
  logic       busy, sat, unsat;

  always #5 clock = ~clock;

  dpll_control dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .num_vars     (num_vars),
    .dec_en       (dec_en),
    .dec_rw       (dec_rw),
    .back_dec_idx (back_dec_idx),
    .dec_idx_in   (dec_idx_in),
    .var_idx_in   (var_idx_in),
    .val_in       (val_in),
    .bcp_req      (bcp_req),
    .bcp_var      (bcp_var),
    .bcp_val      (bcp_val),
    .bcp_level    (bcp_level),
    .bcp_done     (bcp_done),
    .bcp_conflict (bcp_conflict),
    .bt_valid     (bt_valid),
    .bt_level     (bt_level),
    .busy         (busy),
    .sat          (sat),
    .unsat        (unsat)
  );

  // Decider: a position into a per-solve variable/polarity list.
  logic [4:0] perm [0:16];
  logic       pol  [0:16];
  int         dec_pos;

  always @(posedge clock or negedge reset) begin
    if (!reset) dec_pos <= 0;
    else if (dec_en) dec_pos <= dec_rw ? int'(back_dec_idx) : dec_pos + 1;
  end

  always_comb begin
    dec_idx_in = dec_pos[4:0];
    var_idx_in = (dec_pos <= 16) ? perm[dec_pos] : 5'd0;
    val_in     = (dec_pos <= 16) ? pol[dec_pos] : 1'b0;
  end

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference model.
  localparam int EvReq = 0, EvBt = 1, EvSat = 2, EvUnsat = 3;
  typedef struct {int kind; int vr; int vl; int lvl; int back;} ev_t;
  typedef struct {int pos; int vr; int vl; bit fl;} ent_t;

  ev_t  exp_q[$];
  ent_t trail[$];
  int   m_pos, m_n, m_reqs;
  bit   script[$];
  int   pct;

  task automatic push_ev(input int kind, input int vr, input int vl, input int lvl,
                         input int back);
    ev_t e;
    e = '{kind: kind, vr: vr, vl: vl, lvl: lvl, back: back};
    exp_q.push_back(e);
    if (kind == EvReq) m_reqs++;
  endtask

  task automatic model_decide();
    ent_t e;
    if (m_pos == m_n) begin
      push_ev(EvSat, 0, 0, 0, 0);
    end else begin
      e = '{pos: m_pos, vr: int'(perm[m_pos]), vl: int'(pol[m_pos]), fl: 1'b0};
      trail.push_back(e);
      push_ev(EvReq, e.vr, e.vl, trail.size(), -1);
      m_pos++;
    end
  endtask

  task automatic model_backtrack();
    ent_t e;
    while (trail.size() > 0 && trail[trail.size()-1].fl) begin
      push_ev(EvBt, 0, 0, trail.size(), 0);
      void'(trail.pop_back());
    end
    if (trail.size() == 0) begin
      push_ev(EvUnsat, 0, 0, 0, 0);
    end else begin
      push_ev(EvBt, 0, 0, trail.size(), 0);
      e = trail.pop_back();
      e.fl = 1'b1;
      e.vl = 1 - e.vl;
      trail.push_back(e);
      push_ev(EvReq, e.vr, e.vl, trail.size(), e.pos + 1);
      m_pos = e.pos + 1;
    end
  endtask

  function automatic bit pick_conflict();
    if (script.size() > 0) return script.pop_front();
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {dec_en, dec_rw, bcp_req, bcp_val, bt_valid, busy, sat, unsat}, 0);
    check_eq({tag, "_data"}, {back_dec_idx, bcp_var, bcp_level, bt_level}, 0);
  endtask

  int obs_reqs;

  // One solve. busy_start_req / abort_req: pulse start / assert reset when that many
  // requests have been seen (0 = never).
  task automatic run_solve(input int n, input int busy_start_req, input int abort_req);
    ev_t e;
    int  delay;
    bit  pending, finished, c;
    for (int i = 0; i <= 16; i++) begin
      perm[i] = 5'($urandom_range(0, 15));
      pol[i]  = 1'($urandom_range(0, 1));
    end
    trail.delete();
    exp_q.delete();
    m_pos = 0; m_n = n; m_reqs = 0; obs_reqs = 0;
    pending = 0; finished = 0; delay = 0;
    @(negedge clock);
    num_vars = 5'(n);
    start    = 1'b1;
    model_decide();
    @(negedge clock);
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_flags", {sat, unsat}, 0);
    check_eq("start_dec", {dec_en, dec_rw, back_dec_idx}, 7'b1100000);
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge clock);
      start = 1'b0; bcp_done = 1'b0; bcp_conflict = 1'b0;
      if (bt_valid) begin
        check_eq("bt_expected", int'(exp_q.size() > 0 && exp_q[0].kind == EvBt), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("bt_level", bt_level, e.lvl);
        end
      end
      if (bcp_req) begin
        obs_reqs++;
        check_eq("req_expected", int'(exp_q.size() > 0 && exp_q[0].kind == EvReq), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("req_var", bcp_var, e.vr);
          check_eq("req_val", bcp_val, e.vl);
          check_eq("req_level", bcp_level, e.lvl);
          check_eq("req_dec_en", dec_en, 1);
          check_eq("req_dec_rw", dec_rw, int'(e.back >= 0));
          if (e.back >= 0) check_eq("req_back_idx", back_dec_idx, e.back);
        end
        pending = 1;
        delay   = $urandom_range(0, 2);
        if (obs_reqs == busy_start_req) begin
          start    = 1'b1;
          num_vars = 5'((n % 16) + 1);
        end
        if (obs_reqs == abort_req) begin
          reset = 1'b0;
          #1;
          check_all_zero("abort_async");
          @(negedge clock);
          check_all_zero("abort_idle");
          reset = 1'b1;
          return;
        end
      end
      if (sat || unsat) begin
        check_eq("verdict_expected", int'(exp_q.size() > 0 && exp_q[0].kind >= EvSat), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("sat", sat, int'(e.kind == EvSat));
          check_eq("unsat", unsat, int'(e.kind == EvUnsat));
        end
        check_eq("busy_done", busy, 0);
        finished = 1;
      end else if (pending) begin
        if (delay == 0) begin
          c = pick_conflict();
          bcp_done     = 1'b1;
          bcp_conflict = c;
          pending      = 0;
          if (c) model_backtrack();
          else   model_decide();
        end else begin
          delay--;
        end
      end
    end
    check_eq("finished", finished, 1);
    check_eq("events_left", exp_q.size(), 0);
    check_eq("req_count", obs_reqs, m_reqs);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("idle");

    // Three decisions, no conflicts.
    pct = 0; script.delete();
    run_solve(3, 0, 0);
    check_eq("t1_reqs", obs_reqs, 3);
    check_eq("t1_sat", sat, 1);

    // First decision conflicts once, then clean.
    script.delete(); script.push_back(1'b1);
    run_solve(2, 0, 0);
    check_eq("t2_sat", sat, 1);

    // Every propagation conflicts.
    pct = 100; script.delete();
    run_solve(2, 0, 0);
    check_eq("t3_reqs", obs_reqs, 2);
    check_eq("t3_unsat", unsat, 1);

    // Deep conflict chain: levels 3,3,2 then flip at level 1.
    pct = 0; script.delete();
    script.push_back(1'b0); script.push_back(1'b0); script.push_back(1'b1);
    script.push_back(1'b1); script.push_back(1'b1);
    run_solve(3, 0, 0);
    check_eq("t4_sat", sat, 1);

    // Reset while propagating, then a clean solve.
    pct = 30; script.delete();
    run_solve(4, 0, 1);
    pct = 0;
    run_solve(3, 0, 0);
    check_eq("t5_sat", sat, 1);

    // start while busy is ignored.
    pct = 20;
    run_solve(4, 2, 0);

    // Random instances.
    for (int k = 0; k < 12; k++) begin
      pct = $urandom_range(0, 60);
      run_solve($urandom_range(1, 6), 0, 0);
      check_eq("excl", int'(sat && unsat), 0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
